// File: rtl/regfile_write_buffer.sv
// Posted-write buffer in front of the register file write port.
// In-order FIFO of {addr, data}; retires at most one entry per cycle and
// forwards pending data to two decode lookup ports (youngest match wins).
module regfile_write_buffer #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [4:0]                   push_addr,
  input  logic [W-1:0]                 push_data,
  input  logic                         drain_hold,
  output logic                         rf_write_en,
  output logic [4:0]                   rf_write_addr,
  output logic [W-1:0]                 rf_write_data,
  input  logic [4:0]                   lookup_addr1,
  input  logic [4:0]                   lookup_addr2,
  output logic                         lookup_hit1,
  output logic                         lookup_hit2,
  output logic [W-1:0]                 lookup_data1,
  output logic [W-1:0]                 lookup_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned NP = 2;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [W-1:0]  data_q [DEPTH];
  logic [W-1:0]  data_d [DEPTH];

  logic          push_fire;
  logic          drain_fire;
  logic [4:0]    la     [NP];
  logic          hit    [NP];
  logic [W-1:0]  hdata  [NP];

  // Status and drain port, all derived from registered state plus drain_hold
  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign push_ready    = (count_q != CW'(DEPTH));
  assign rf_write_en   = (count_q != '0) && !drain_hold;
  assign rf_write_addr = rf_write_en ? addr_q[head_q] : 5'd0;
  assign rf_write_data = rf_write_en ? data_q[head_q] : '0;

  assign push_fire  = push_valid && push_ready && (push_addr != 5'd0);
  assign drain_fire = rf_write_en;

  assign la[0]        = lookup_addr1;
  assign la[1]        = lookup_addr2;
  assign lookup_hit1  = hit[0];
  assign lookup_hit2  = hit[1];
  assign lookup_data1 = hdata[0];
  assign lookup_data2 = hdata[1];

  // Forwarding: scan oldest to youngest so the youngest match overrides
  always_comb begin
    logic [PW-1:0] idx;
    for (int p = 0; p < int'(NP); p++) begin
      hit[p]   = 1'b0;
      hdata[p] = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        idx = head_q + PW'(k);
        if (valid_q[idx] && (la[p] != 5'd0) && (addr_q[idx] == la[p])) begin
          hit[p]   = 1'b1;
          hdata[p] = data_q[idx];
        end
      end
    end
  end

  // Next-state: enqueue at tail, retire at head, track occupancy
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push_fire) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = push_addr;
      data_d[tail_q]  = push_data;
      tail_d          = tail_q + PW'(1);
    end
    if (drain_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    count_d = count_q + CW'(push_fire) - CW'(drain_fire);
  end

  // State registers; reset discards every pending entry
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer (W=32, DEPTH=4).
module tb_regfile_write_buffer;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [4:0]  push_addr;
  logic [W-1:0] push_data;
  logic        drain_hold;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [W-1:0] rf_write_data;
  logic [4:0]  lookup_addr1, lookup_addr2;
  logic        lookup_hit1, lookup_hit2;
  logic [W-1:0] lookup_data1, lookup_data2;
  logic [2:0]  count;
  logic        empty;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t exp_q[$];
  ent_t e;

  regfile_write_buffer #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data),
    .drain_hold(drain_hold),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .lookup_addr1(lookup_addr1), .lookup_addr2(lookup_addr2),
    .lookup_hit1(lookup_hit1), .lookup_hit2(lookup_hit2),
    .lookup_data1(lookup_data1), .lookup_data2(lookup_data2),
    .count(count), .empty(empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance past the next rising edge; inputs are changed right after this
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    push_valid = 1'b0; push_addr = '0; push_data = '0;
    drain_hold = 1'b0; lookup_addr1 = '0; lookup_addr2 = '0;
    cyc(); cyc();
    settle();
    chk("rst_ready", 32'(push_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_en", 32'(rf_write_en), 32'd0);
    chk("rst_waddr", 32'(rf_write_addr), 32'd0);
    chk("rst_wdata", rf_write_data, 32'd0);
    chk("rst_hit1", 32'(lookup_hit1), 32'd0);
    chk("rst_hit2", 32'(lookup_hit2), 32'd0);
    chk("rst_ldata1", lookup_data1, 32'd0);
    chk("rst_ldata2", lookup_data2, 32'd0);
    cyc();
    reset = 1'b0;

    // Single push: one-cycle latency, lookup visible next cycle
    push(5'd5, 32'hDEADBEEF);
    lookup_addr1 = 5'd5;
    settle();
    chk("same_cycle_nohit", 32'(lookup_hit1), 32'd0);
    cyc();
    push_valid = 1'b0;
    settle();
    chk("single_en", 32'(rf_write_en), 32'd1);
    chk("single_addr", 32'(rf_write_addr), 32'd5);
    chk("single_data", rf_write_data, 32'hDEADBEEF);
    chk("single_hit", 32'(lookup_hit1), 32'd1);
    chk("single_ldata", lookup_data1, 32'hDEADBEEF);
    cyc();
    settle();
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_hit_gone", 32'(lookup_hit1), 32'd0);
    chk("single_en_off", 32'(rf_write_en), 32'd0);

    // Fill to full while held, refuse a fifth push, then drain in order
    drain_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(5'(i), 32'h100 + 32'(i));
      cyc();
    end
    push_valid = 1'b0;
    settle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(push_ready), 32'd0);
    chk("hold_en", 32'(rf_write_en), 32'd0);
    push(5'd6, 32'h600);
    lookup_addr1 = 5'd6;
    settle();
    chk("full_ready_pv", 32'(push_ready), 32'd0);
    cyc();
    push_valid = 1'b0;
    settle();
    chk("refused_count", 32'(count), 32'd4);
    chk("refused_nohit", 32'(lookup_hit1), 32'd0);
    drain_hold = 1'b0;
    settle();
    for (int i = 1; i <= 4; i++) begin
      chk("fill_en", 32'(rf_write_en), 32'd1);
      chk("fill_addr", 32'(rf_write_addr), 32'(i));
      chk("fill_data", rf_write_data, 32'h100 + 32'(i));
      cyc();
      settle();
    end
    chk("fill_empty", 32'(empty), 32'd1);
    chk("fill_en_off", 32'(rf_write_en), 32'd0);

    // Youngest match wins; both writes still reach the register file
    drain_hold = 1'b1;
    push(5'd7, 32'h11); cyc();
    push(5'd7, 32'h22); cyc();
    push_valid = 1'b0;
    lookup_addr2 = 5'd7;
    settle();
    chk("young_hit", 32'(lookup_hit2), 32'd1);
    chk("young_data", lookup_data2, 32'h22);
    drain_hold = 1'b0;
    settle();
    chk("young_w1_addr", 32'(rf_write_addr), 32'd7);
    chk("young_w1_data", rf_write_data, 32'h11);
    chk("young_drain_data", lookup_data2, 32'h22);
    cyc();
    settle();
    chk("young_after1_hit", 32'(lookup_hit2), 32'd1);
    chk("young_after1_data", lookup_data2, 32'h22);
    chk("young_w2_en", 32'(rf_write_en), 32'd1);
    chk("young_w2_data", rf_write_data, 32'h22);
    cyc();
    settle();
    chk("young_after2_hit", 32'(lookup_hit2), 32'd0);
    chk("young_after2_data", lookup_data2, 32'd0);

    // Register zero push is accepted and dropped
    push(5'd0, 32'hFFFF);
    lookup_addr1 = 5'd0;
    settle();
    chk("r0_ready", 32'(push_ready), 32'd1);
    cyc();
    push_valid = 1'b0;
    settle();
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_en", 32'(rf_write_en), 32'd0);
    chk("r0_hit", 32'(lookup_hit1), 32'd0);

    // Sustained push+drain at count 2 across pointer wrap
    drain_hold = 1'b1;
    exp_q.delete();
    push(5'd8, 32'h200); exp_q.push_back({5'd8, 32'h200}); cyc();
    push(5'd9, 32'h201); exp_q.push_back({5'd9, 32'h201}); cyc();
    drain_hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push(5'(10 + k), 32'h300 + 32'(k));
      settle();
      e = exp_q.pop_front();
      chk("stream_count", 32'(count), 32'd2);
      chk("stream_en", 32'(rf_write_en), 32'd1);
      chk("stream_addr", 32'(rf_write_addr), 32'(e.a));
      chk("stream_data", rf_write_data, e.d);
      exp_q.push_back({5'(10 + k), 32'h300 + 32'(k)});
      cyc();
    end
    push_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      e = exp_q.pop_front();
      chk("tail_en", 32'(rf_write_en), 32'd1);
      chk("tail_addr", 32'(rf_write_addr), 32'(e.a));
      chk("tail_data", rf_write_data, e.d);
      cyc();
    end
    settle();
    chk("stream_empty", 32'(empty), 32'd1);

    // Asynchronous reset with three entries pending
    drain_hold = 1'b1;
    push(5'd11, 32'hB0); cyc();
    push(5'd12, 32'hC0); cyc();
    push(5'd13, 32'hD0); cyc();
    push_valid = 1'b0;
    lookup_addr1 = 5'd12;
    lookup_addr2 = 5'd13;
    drain_hold = 1'b0;
    settle();
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_hit1", 32'(lookup_hit1), 32'd1);
    chk("pre_rst_en", 32'(rf_write_en), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_en", 32'(rf_write_en), 32'd0);
    chk("arst_hit1", 32'(lookup_hit1), 32'd0);
    chk("arst_hit2", 32'(lookup_hit2), 32'd0);
    chk("arst_ldata1", lookup_data1, 32'd0);
    chk("arst_ldata2", lookup_data2, 32'd0);
    chk("arst_ready", 32'(push_ready), 32'd1);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("post_rst_en", 32'(rf_write_en), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_buffer.md
# regfile_write_buffer

Posted-write buffer placed in front of the 32-entry register file on its write port. Execute and load writebacks are pushed into an in-order FIFO, and the buffer retires at most one entry per cycle into the register file. Entries still pending are forwarded on two lookup ports, so decode reads stay coherent while writes wait in the buffer.

## Interface
- W, 32, data width of one register.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- push_valid  in  1  a writeback request is presented this cycle.
- push_ready  out  1  the buffer can accept a push; equals !full.
- push_addr  in  5  destination register number.
- push_data  in  W  value to write.
- drain_hold  in  1  when high, no entry is retired this cycle.
- rf_write_en  out  1  write strobe to the register file.
- rf_write_addr  out  5  register number of the head entry.
- rf_write_data  out  W  data of the head entry.
- lookup_addr1, lookup_addr2  in  5 each  decode read addresses.
- lookup_hit1, lookup_hit2  out  1 each  a pending entry matches the lookup address.
- lookup_data1, lookup_data2  out  W each  data of the youngest matching entry; 0 when there is no hit.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- empty  out  1  count == 0.

## Operation
- Storage: DEPTH entries of {addr[4:0], data[W-1:0]}, with a head pointer, a tail pointer and count. Both pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Push is accepted when push_valid && push_ready.
  - If push_addr != 0, the entry is written at tail, tail increments, and count increments.
  - If push_addr == 0, the push is accepted but nothing is enqueued, because register 0 is hard-wired to zero.
- Drain: rf_write_en = !empty && !drain_hold. When rf_write_en is 1, rf_write_addr and rf_write_data come from the head entry, and head increments at the edge.
- When rf_write_en = 0, rf_write_addr and rf_write_data are driven to 0.
- Push and drain in the same cycle: count is unchanged. If the buffer was full, push_ready is 0, so the push is refused even though a slot frees at that edge.
- Lookup (combinational):
  - An entry matches when it is occupied and its addr == lookup_addr.
  - The head entry being drained this cycle still counts as occupied.
  - If several entries match, the youngest one (closest to tail) supplies the data.
  - lookup_addr == 0 never hits.
  - A push arriving in the same cycle is not visible to lookup until the next cycle.
- Writes to the same register are never merged. Each accepted push with a nonzero address produces exactly one register file write, in push order.
- Reset asserted, asynchronously: head, tail and count go to 0, and occupancy is cleared. Stored entries are discarded and never written.
- Reset is independent of any operation in flight. A push or drain in the cycle reset asserts has no effect.

## Timing
- Reset values: push_ready = 1, empty = 1, count = 0, rf_write_en = 0, rf_write_addr = 0, rf_write_data = 0, lookup_hit1/2 = 0, lookup_data1/2 = 0.
- Push-to-register-file latency is one cycle when the buffer is empty and drain_hold = 0:
  - The push is captured at edge N.
  - rf_write_en is high during cycle N+1.
  - The register file writes at edge N+1.
- Lookup hit latency: visible in the cycle after the push edge, and remains visible up to and including the cycle in which the entry is drained.
- Throughput: one push and one drain per cycle, sustained.
- push_ready is a function of registered state only, with no combinational path from push_valid or drain_hold.
- rf_write_en depends combinationally on drain_hold.
- lookup outputs depend combinationally on lookup_addr and on registered state only.

## Test plan
- Reset then single push: push addr 5, data 0xDEADBEEF in cycle 0.
  - Cycle 1: rf_write_en = 1, rf_write_addr = 5, rf_write_data = 0xDEADBEEF, lookup_addr1 = 5 gives hit = 1 with the same data.
  - Cycle 2: empty = 1, hit = 0.
- Fill and full: drain_hold = 1, push addrs 1..4.
  - count reaches 4 and push_ready = 0.
  - A 5th push (addr 6) is refused, and count stays 4.
  - Release drain_hold: writes 1, 2, 3, 4 appear in order on consecutive cycles.
- Youngest match: drain_hold = 1, push (7, 0x11) then (7, 0x22).
  - lookup_addr2 = 7 gives 0x22.
  - After one drain it still gives 0x22. After the second drain, hit = 0.
  - The register file sees 0x11 then 0x22.
- Register zero: push addr 0, data 0xFFFF.
  - push_ready stays 1, count stays 0, no rf_write_en.
  - lookup_addr1 = 0 gives hit = 0.
- Simultaneous push and drain with count = 2:
  - count stays 2, and the pointers wrap correctly across at least 2×DEPTH pushes.
  - The write order matches the push order exactly.
- Reset mid-operation: with 3 entries pending, assert reset between edges.
  - count, empty, rf_write_en and the lookup outputs take their reset values immediately, without a clock edge.
  - After reset deasserts, none of the 3 discarded entries is ever written.
